// File: rtl/dcache_to_icache_snoop_queue_pkg.sv
// Shared defaults for the data-cache to instruction-cache line-invalidate queue.
// Instances override these through their parameters.
package dcache_to_icache_snoop_queue_pkg;

    localparam int SNOOP_ADDR_W     = 32;
    localparam int SNOOP_LINE_LOG2  = 4;
    localparam int SNOOP_DEPTH_LOG2 = 5;

    // Width of a stored line tag once the in-line byte offset is dropped.
    function automatic int line_tag_width(input int addr_w, input int line_log2);
        return addr_w - line_log2;
    endfunction

endpackage

// File: rtl/dcache_to_icache_snoop_match.sv
// Parallel line-tag comparator: hit when any valid, non-excluded entry equals the tag.
module dcache_to_icache_snoop_match #(
    parameter int DEPTH = 32,
    parameter int TAG_W = 28
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] entries_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0]            exclude_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        hit_o
);

    logic [DEPTH-1:0] eq;

    always_comb begin
        eq = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eq[i] = (entries_i[i] == tag_i);
        end
    end

    assign hit_o = |(eq & valid_i & ~exclude_i);

endmodule

// File: rtl/dcache_to_icache_snoop_queue.sv
// Line-invalidate FIFO from dcache writes to icache; overflow escalates to flush-all.
// Define DCACHE_TO_ICACHE_COALESCE_EN to discard writes whose line is already pending.
module dcache_to_icache_snoop_queue
    import dcache_to_icache_snoop_queue_pkg::*;
#(
    parameter int ADDR_W     = SNOOP_ADDR_W,
    parameter int LINE_LOG2  = SNOOP_LINE_LOG2,
    parameter int DEPTH_LOG2 = SNOOP_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dcachetoicache_write_do,
    input  logic [ADDR_W-1:0]     dcachetoicache_write_address,
    input  logic                  dcachetoicache_accept_do,
    output logic [ADDR_W-1:0]     dcachetoicache_accept_address,
    output logic                  dcachetoicache_accept_empty,
    output logic                  dcachetoicache_accept_flush_all,
    output logic [DEPTH_LOG2:0]   dcachetoicache_usedw
);

    localparam int TAG_W = line_tag_width(ADDR_W, LINE_LOG2);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH-1:0][TAG_W-1:0] mem_q;
    logic [DEPTH_LOG2-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]       wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]         count_q, count_d;
    logic                        ovf_q, ovf_d;

    logic [TAG_W-1:0] wr_tag;
    logic             not_empty, full, pop_ok, flush, hit, push_ok, drop_full;
    logic             unused_line_offset;

    assign wr_tag             = dcachetoicache_write_address[ADDR_W-1:LINE_LOG2];
    assign unused_line_offset = ^dcachetoicache_write_address[LINE_LOG2-1:0];

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop_ok    = dcachetoicache_accept_do & not_empty & ~ovf_q;
    assign flush     = dcachetoicache_accept_do & ovf_q;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push_ok   = dcachetoicache_write_do & ~ovf_q & ~hit & (~full | pop_ok);
    assign drop_full = dcachetoicache_write_do & ~ovf_q & ~hit & full & ~pop_ok;

`ifdef DCACHE_TO_ICACHE_COALESCE_EN
    logic [DEPTH-1:0] valid_q, valid_d, exclude;

    always_comb begin
        exclude = '0;
        if (pop_ok) exclude[rd_ptr_q] = 1'b1;
    end

    dcache_to_icache_snoop_match #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_match (
        .entries_i (mem_q),
        .valid_i   (valid_q),
        .exclude_i (exclude),
        .tag_i     (wr_tag),
        .hit_o     (hit)
    );

    // Clear before set: a full push+pop reuses the head slot and must stay valid.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (pop_ok)  valid_d[rd_ptr_q] = 1'b0;
            if (push_ok) valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
            if (drop_full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_tag;
    end

    assign dcachetoicache_accept_address   = not_empty ? {mem_q[rd_ptr_q], {LINE_LOG2{1'b0}}} : '0;
    assign dcachetoicache_accept_empty     = ~not_empty & ~ovf_q;
    assign dcachetoicache_accept_flush_all = ovf_q;
    assign dcachetoicache_usedw            = count_q;

endmodule

// File: tb/tb_dcache_to_icache_snoop_queue.sv
// Self-checking bench for the snoop queue (depth 4) with a queue-based reference model.
module tb_dcache_to_icache_snoop_queue;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
`ifdef DCACHE_TO_ICACHE_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_do = 1'b0;
    logic [31:0] write_address = '0;
    logic        accept_do = 1'b0;
    logic [31:0] accept_address;
    logic        accept_empty;
    logic        flush_all;
    logic [2:0]  usedw;

    int errors = 0;
    int checks = 0;

    logic [27:0] m_q[$];
    bit          m_ovf = 1'b0;

    dcache_to_icache_snoop_queue #(
        .ADDR_W     (32),
        .LINE_LOG2  (4),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .dcachetoicache_write_do         (write_do),
        .dcachetoicache_write_address    (write_address),
        .dcachetoicache_accept_do        (accept_do),
        .dcachetoicache_accept_address   (accept_address),
        .dcachetoicache_accept_empty     (accept_empty),
        .dcachetoicache_accept_flush_all (flush_all),
        .dcachetoicache_usedw            (usedw)
    );

    always #5 clk = ~clk;

    // Reference: a queue of line tags plus an overflow bit, following the queue rules directly.
    function automatic void model(input bit rst, input bit wr, input logic [31:0] addr, input bit acc);
        bit          pop;
        bit          hit;
        logic [27:0] t;
        t = addr[31:4];
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        if (m_ovf) begin
            if (acc) begin
                m_q.delete();
                m_ovf = 1'b0;
            end
            return;
        end
        pop = acc && (m_q.size() > 0);
        hit = 1'b0;
        if (COAL && wr) begin
            foreach (m_q[i]) begin
                if (!(pop && i == 0) && m_q[i] == t) hit = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (wr && !hit) begin
            if (m_q.size() < DEPTH) m_q.push_back(t);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic step(input bit rst, input bit wr, input logic [31:0] addr, input bit acc);
        rst_n         = !rst;
        write_do      = wr;
        write_address = addr;
        accept_do     = acc;
        @(posedge clk);
        model(rst, wr, addr, acc);
        #1;
        rst_n     = 1'b1;
        write_do  = 1'b0;
        accept_do = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, base * (i + 1), 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL reset_usedw got=%0d exp=0", usedw); end
        checks++; if (accept_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", accept_empty); end
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush_all); end
        checks++; if (accept_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", accept_address); end
    endtask

    task automatic test_basic_order();
        step(1'b0, 1'b1, 32'h0000_1234, 1'b0);
        checks++; if (usedw !== 3'd1) begin errors++; $display("FAIL basic_usedw_a got=%0d exp=1", usedw); end
        checks++; if (accept_empty !== 1'b0) begin errors++; $display("FAIL basic_empty_a got=%b exp=0", accept_empty); end
        checks++; if (accept_address !== 32'h0000_1230) begin errors++; $display("FAIL basic_addr_a got=%h exp=00001230", accept_address); end
        step(1'b0, 1'b1, 32'h0000_5678, 1'b0);
        checks++; if (usedw !== 3'd2) begin errors++; $display("FAIL basic_usedw_b got=%0d exp=2", usedw); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (usedw !== 3'd1) begin errors++; $display("FAIL basic_usedw_c got=%0d exp=1", usedw); end
        checks++; if (accept_address !== 32'h0000_5670) begin errors++; $display("FAIL basic_addr_b got=%h exp=00005670", accept_address); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL basic_usedw_d got=%0d exp=0", usedw); end
        checks++; if (accept_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_end got=%b exp=1", accept_empty); end
        // Pop on empty is ignored.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL basic_pop_empty got=%0d exp=0", usedw); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a[4];
        exp_a = '{32'h30, 32'h40, 32'hA0, 32'hB0};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'((i + 1) << 4), 1'b0);
        checks++; if (usedw !== 3'd4) begin errors++; $display("FAIL wrap_full got=%0d exp=4", usedw); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (accept_address !== 32'((i + 1) << 4)) begin
                errors++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, accept_address, 32'((i + 1) << 4));
            end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        step(1'b0, 1'b1, 32'hA0, 1'b0);
        step(1'b0, 1'b1, 32'hB0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (accept_address !== exp_a[i]) begin
                errors++; $display("FAIL wrap_order%0d got=%h exp=%h", i, accept_address, exp_a[i]);
            end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        checks++; if (accept_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", accept_empty); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_a[4];
        exp_a = '{32'h200, 32'h300, 32'h400, 32'hC0};
        fill(32'h100);
        step(1'b0, 1'b1, 32'hC0, 1'b1);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL fullpp_flush got=%b exp=0", flush_all); end
        checks++; if (usedw !== 3'd4) begin errors++; $display("FAIL fullpp_usedw got=%0d exp=4", usedw); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (accept_address !== exp_a[i]) begin
                errors++; $display("FAIL fullpp_order%0d got=%h exp=%h", i, accept_address, exp_a[i]);
            end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL fullpp_drain got=%0d exp=0", usedw); end
    endtask

    task automatic test_overflow();
        fill(32'h100);
        step(1'b0, 1'b1, 32'hD0, 1'b0);
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL ovf_flush got=%b exp=1", flush_all); end
        checks++; if (accept_empty !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", accept_empty); end
        step(1'b0, 1'b1, 32'hE0, 1'b0);
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", flush_all); end
        checks++; if (usedw !== 3'd4) begin errors++; $display("FAIL ovf_usedw got=%0d exp=4", usedw); end
        step(1'b0, 1'b1, 32'hF0, 1'b1);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", flush_all); end
        checks++; if (accept_empty !== 1'b1) begin errors++; $display("FAIL ovf_clear_empty got=%b exp=1", accept_empty); end
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL ovf_clear_usedw got=%0d exp=0", usedw); end
        step(1'b0, 1'b1, 32'h55, 1'b0);
        checks++; if (accept_address !== 32'h50) begin errors++; $display("FAIL ovf_resume got=%h exp=50", accept_address); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_coalesce();
        logic [2:0] exp_u;
        exp_u = COAL ? 3'd1 : 3'd2;
        step(1'b0, 1'b1, 32'h1230, 1'b0);
        step(1'b0, 1'b1, 32'h123C, 1'b0);
        checks++; if (usedw !== exp_u) begin errors++; $display("FAIL coal_dup got=%0d exp=%0d", usedw, exp_u); end
        step(1'b0, 1'b1, 32'h1230, 1'b1);
        checks++; if (usedw !== exp_u) begin errors++; $display("FAIL coal_pop_same got=%0d exp=%0d", usedw, exp_u); end
        checks++; if (accept_address !== 32'h1230) begin errors++; $display("FAIL coal_head got=%h exp=1230", accept_address); end
        for (int i = 0; i < int'(exp_u); i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (accept_empty !== 1'b1) begin errors++; $display("FAIL coal_drain got=%b exp=1", accept_empty); end
        // Write on empty with a simultaneous pop: the write lands, the pop is ignored.
        step(1'b0, 1'b1, 32'h777, 1'b1);
        checks++; if (usedw !== 3'd1) begin errors++; $display("FAIL empty_wr_pop got=%0d exp=1", usedw); end
        checks++; if (accept_address !== 32'h770) begin errors++; $display("FAIL empty_wr_pop_addr got=%h exp=770", accept_address); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid_overflow();
        fill(32'h100);
        step(1'b0, 1'b1, 32'hD0, 1'b0);
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL rstovf_pre got=%b exp=1", flush_all); end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL rstovf_flush got=%b exp=0", flush_all); end
        checks++; if (accept_empty !== 1'b1) begin errors++; $display("FAIL rstovf_empty got=%b exp=1", accept_empty); end
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL rstovf_usedw got=%0d exp=0", usedw); end
        checks++; if (accept_address !== 32'h0) begin errors++; $display("FAIL rstovf_addr got=%h exp=0", accept_address); end
    endtask

    task automatic test_random();
        bit          rst, wr, acc;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            wr   = ($urandom_range(0, 99) < 60);
            acc  = ($urandom_range(0, 99) < 35);
            addr = {24'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
            step(rst, wr, addr, acc);
            checks++;
            if (usedw !== 3'(m_q.size())) begin
                errors++; $display("FAIL rand_usedw cyc=%0d got=%0d exp=%0d", n, usedw, m_q.size());
            end
            checks++;
            if (flush_all !== m_ovf) begin
                errors++; $display("FAIL rand_flush cyc=%0d got=%b exp=%b", n, flush_all, m_ovf);
            end
            checks++;
            if (accept_empty !== (m_q.size() == 0 && !m_ovf)) begin
                errors++; $display("FAIL rand_empty cyc=%0d got=%b", n, accept_empty);
            end
            if (m_q.size() > 0 && !m_ovf) begin
                exp_addr = {m_q[0], 4'h0};
                checks++;
                if (accept_address !== exp_addr) begin
                    errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", n, accept_address, exp_addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_wrap();
        test_full_push_pop();
        test_overflow();
        test_coalesce();
        test_reset_mid_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
